fifo_rd_stream: RTL and testbench

Single-clock read-side drain engine for the standard-mode (non-FWFT) FIFO read port. It pulls words from the FIFO and presents them on a valid/ready stream with no bubbles. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency. It also frames the stream into fixed-length bursts (`m_last`) and counts delivered words. It sits in the read clock domain between the FIFO and downstream SIFT pipeline consumers.

---
 rtl/fifo_rd_stream.sv | 67 ++++++
 tb/tb_fifo_rd_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a standard-mode FIFO read port into a bubble-free valid/ready stream
// Ports: rclk/rrst_n (async active-low), rclr sync clear; fifo_rempty/fifo_ren/fifo_rdata to the FIFO;
//        m_valid/m_ready/m_data/m_last stream out; word_cnt delivered words; pend_cnt skid occupancy.
module fifo_rd_stream #(
  parameter int dw        = 8,
  parameter int burst_len = 16,
  parameter int bw        = 16
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic          rclr,
  input  logic          fifo_rempty,
  output logic          fifo_ren,
  input  logic [dw-1:0] fifo_rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [dw-1:0] m_data,
  output logic          m_last,
  output logic [15:0]   word_cnt,
  output logic [1:0]    pend_cnt
);
  localparam logic [bw-1:0] last_beat = bw'(burst_len - 1);
  logic [dw-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]    occ_q, occ_d, slot;
  logic          inflight_q, last_q, last_d, pop;
  logic [bw-1:0] beat_q, beat_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    level;
  always_comb begin
    pop      = (occ_q != 2'd0) & m_ready;
    // occupancy after this edge, counting the word already in flight
    level    = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    fifo_ren = rrst_n & ~rclr & ~fifo_rempty & (level <= 3'd1);
    // returning word lands just behind whatever survives the pop
    slot     = occ_q - 2'(pop);
    head_d   = (inflight_q && slot == 2'd0) ? fifo_rdata : (pop ? tail_q : head_q);
    tail_d   = (inflight_q && slot == 2'd1) ? fifo_rdata : tail_q;
    occ_d    = rclr ? 2'd0 : level[1:0];
    beat_d   = rclr ? '0 : (pop ? ((beat_q == last_beat) ? '0 : beat_q + 1'b1) : beat_q);
    cnt_d    = rclr ? 16'd0 : cnt_q + 16'(pop);
    last_d   = (occ_d != 2'd0) & (beat_d == last_beat);
  end
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      cnt_q      <= 16'd0;
      last_q     <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_ren;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end
  assign m_valid  = occ_q != 2'd0;
  assign m_data   = head_q;
  assign m_last   = last_q;
  assign word_cnt = cnt_q;
  assign pend_cnt = occ_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of fifo_rd_stream against a FIFO model whose word value equals its index
module tb_fifo_rd_stream;
  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0, rclr = 1'b0, m_ready = 1'b0, force_empty = 1'b0;
  logic        fifo_rempty, fifo_ren, m_valid, m_last;
  logic [7:0]  fifo_rdata = 8'd0, m_data;
  logic [15:0] word_cnt;
  logic [1:0]  pend_cnt;
  logic        b_rst_n = 1'b0, b_ren, b_valid, b_last;
  logic [7:0]  b_rdata = 8'h5a, b_data;
  logic [15:0] b_cnt;
  logic [1:0]  b_pend;
  int          level = 0, rd_ptr = 0, n_rx = 0, viol = 0, nb = 0, bad_last = 0;
  int          vectors = 0, miscompares = 0;
  logic [7:0]  rx_data [256];
  logic        rx_last [256];
  always #5 rclk = ~rclk;
  assign fifo_rempty = force_empty | (rd_ptr >= level);
  fifo_rd_stream #(.dw(8), .burst_len(16), .bw(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rclr(rclr), .fifo_rempty(fifo_rempty), .fifo_ren(fifo_ren),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .word_cnt(word_cnt), .pend_cnt(pend_cnt));
  fifo_rd_stream #(.dw(8), .burst_len(1), .bw(1)) dut_b (
    .rclk(rclk), .rrst_n(b_rst_n), .rclr(1'b0), .fifo_rempty(1'b0), .fifo_ren(b_ren),
    .fifo_rdata(b_rdata), .m_valid(b_valid), .m_ready(1'b1), .m_data(b_data),
    .m_last(b_last), .word_cnt(b_cnt), .pend_cnt(b_pend));
  always @(posedge rclk) begin
    if (fifo_ren) begin
      fifo_rdata <= rd_ptr[7:0];
      rd_ptr     <= rd_ptr + 1;
    end
    if (fifo_ren && fifo_rempty) viol <= viol + 1;
    if (m_valid && m_ready && n_rx < 256) begin
      rx_data[n_rx] <= m_data;
      rx_last[n_rx] <= m_last;
      n_rx          <= n_rx + 1;
    end
    if (b_valid) begin
      nb <= nb + 1;
      if (!b_last) bad_last <= bad_last + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask
  task automatic wait_rx(input int n, input int budget, output int cycles);
    cycles = 0;
    while (n_rx < n && cycles < budget) begin
      tick();
      cycles++;
    end
    chk("rx_timeout", 32'(n_rx >= n), 1);
  endtask
  task automatic chk_words(input string tag, input int first, input int n, input int val0, input int beat0);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, rx_data[first+i], 8'(val0 + i));
      chk({tag, "_last"}, rx_last[first+i], 32'(((beat0 + i) % 16) == 15));
    end
  endtask
  initial begin
    int cyc, base, p, rem;
    level = 20;
    #3;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_ren", fifo_ren, 0);
    level = 0;
    tick();
    rrst_n = 1'b1;
    tick(); tick(); tick();
    chk("idle_ren", fifo_ren, 0);
    chk("idle_valid", m_valid, 0);
    level = 20;
    m_ready = 1'b1;
    #1;
    chk("lat_ren0", fifo_ren, 1);
    chk("lat_valid0", m_valid, 0);
    tick();
    chk("lat_valid1", m_valid, 0);
    tick();
    chk("lat_valid2", m_valid, 1);
    chk("lat_data2", m_data, 0);
    wait_rx(20, 60, cyc);
    chk_words("stream", 0, 20, 0, 0);
    chk("stream_cnt", word_cnt, 20);
    chk("stream_pend", pend_cnt, 0);
    level = 40;
    tick(); tick(); tick();
    m_ready = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("bp_pend", pend_cnt, 2);
    chk("bp_ren", fifo_ren, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_hold", m_data, 8'(n_rx));
    chk("bp_reads", rd_ptr, n_rx + 2);
    rem = 40 - n_rx;
    m_ready = 1'b1;
    wait_rx(40, 80, cyc);
    chk("bp_nobubble", cyc, rem);
    chk_words("bp", 20, 20, 20, 4);
    chk("bp_cnt", word_cnt, 40);
    level = 60;
    for (int k = 0; k < 2000 && n_rx < 60; k++) begin
      force_empty = ((k / 3) % 2) == 1;
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    force_empty = 1'b0;
    m_ready = 1'b1;
    chk("sparse_done", 32'(n_rx), 60);
    chk("sparse_underflow", viol, 0);
    chk_words("sparse", 40, 20, 40, 8);
    chk("sparse_cnt", word_cnt, 60);
    level = 200;
    tick(); tick(); tick(); tick();
    chk("pre_clr_pend", pend_cnt, 1);
    rclr = 1'b1;
    m_ready = 1'b0;
    #1;
    chk("clr_ren", fifo_ren, 0);
    tick();
    rclr = 1'b0;
    chk("clr_valid", m_valid, 0);
    chk("clr_cnt", word_cnt, 0);
    chk("clr_pend", pend_cnt, 0);
    p = rd_ptr;
    base = n_rx;
    m_ready = 1'b1;
    wait_rx(base + 20, 60, cyc);
    chk_words("clr", base, 20, p, 0);
    chk("clr_cnt20", word_cnt, 20);
    m_ready = 1'b0;
    tick(); tick(); tick();
    chk("mid_pend", pend_cnt, 2);
    rrst_n = 1'b0;
    #1;
    chk("mid_valid", m_valid, 0);
    chk("mid_data", m_data, 0);
    chk("mid_last", m_last, 0);
    chk("mid_cnt", word_cnt, 0);
    chk("mid_pendz", pend_cnt, 0);
    chk("mid_ren", fifo_ren, 0);
    level = rd_ptr;
    tick(); tick();
    rrst_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_ren", fifo_ren, 0);
    chk("post_rst_valid", m_valid, 0);
    p = rd_ptr;
    base = n_rx;
    level = rd_ptr + 16;
    m_ready = 1'b1;
    wait_rx(base + 16, 60, cyc);
    chk_words("post_rst", base, 16, p, 0);
    chk("post_rst_cnt", word_cnt, 16);
    b_rst_n = 1'b1;
    cyc = 0;
    while (nb < 65535 && cyc < 70000) begin
      tick();
      cyc++;
    end
    chk("wrap_reach", nb, 65535);
    chk("wrap_ffff", b_cnt, 16'hffff);
    chk("wrap_last1", b_last, 1);
    tick();
    chk("wrap_0000", b_cnt, 16'h0000);
    tick();
    chk("wrap_0001", b_cnt, 16'h0001);
    chk("wrap_beats", nb, 65537);
    chk("wrap_all_last", bad_last, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
